// File: rtl/axis_pkg.sv
// Purpose : shared types, constants and helpers for the byte-stream blocks.
// Contents: BYTE_W lane width, serializer FSM state type, single-bit mask test.
package axis_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned MASK_MAX_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // True when the mask is nonzero and has exactly one bit set; callers zero-extend.
    function automatic logic onehot0_is_single(input logic [MASK_MAX_W-1:0] mask);
        return (mask != '0) && ((mask & (mask - MASK_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/axis_byte_serializer_if.sv
// Purpose : AXI-Stream bundle (valid/ready/data/keep/last) of configurable width.
// Modports: master drives tvalid/tdata/tkeep/tlast and samples tready;
//           slave is the mirror image.
interface axis_byte_serializer_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);

endinterface

// File: rtl/lsb_onehot_enc.sv
// Purpose : isolate the lowest set bit of a mask as one-hot and as a binary index.
// Ports   : i_mask   - input mask
//           o_onehot - one-hot lowest set bit (zero when mask is zero)
//           o_index  - binary index of that bit (zero when mask is zero)
module lsb_onehot_enc #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_mask,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_index
);

    // Two's-complement trick: x & -x keeps only the lowest set bit.
    assign o_onehot = i_mask & (~i_mask + N'(1));

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        o_index = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axis_byte_serializer.sv
// Purpose : emit the kept bytes of wide AXI-Stream beats one per cycle, lane 0
//           first, skipping null lanes and preserving packet boundaries.
// Ports   : ACLK, reset     - clock and synchronous active-high reset
//           s_axis (slave)  - DATA_WIDTH-wide input beats with tkeep/tlast
//           m_axis (master) - 8-bit output stream, tlast on final kept byte
//           err_null_last   - one-cycle pulse when a tlast beat with no kept
//                             lanes is dropped
module axis_byte_serializer
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           ACLK,
    input  logic                           reset,
    axis_byte_serializer_if.slave          s_axis,
    axis_byte_serializer_if.master         m_axis,
    output logic                           err_null_last
);

    localparam int unsigned LANES = DATA_WIDTH / BYTE_W;
    localparam int unsigned IDX_W = $clog2(LANES);

    ser_state_t            r_state;
    ser_state_t            w_state_n;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_n;
    logic [LANES-1:0]      r_rem;
    logic [LANES-1:0]      w_rem_n;
    logic                  r_last;
    logic                  w_last_n;
    logic                  r_err;
    logic                  w_err_n;

    logic [LANES-1:0]      w_cur_oh;
    logic [IDX_W-1:0]      w_cur_idx;
    logic                  w_single;
    logic                  w_s_ready;
    logic                  w_s_hs;
    logic                  w_m_hs;
    logic                  w_s_null;

    // Current lane select and the bit to clear on each output handshake.
    lsb_onehot_enc #(.N(LANES)) u_lane_enc (
        .i_mask   (r_rem),
        .o_onehot (w_cur_oh),
        .o_index  (w_cur_idx)
    );

    assign w_single = onehot0_is_single(MASK_MAX_W'(r_rem));

    // Accept a new beat when empty, or when the final held byte leaves this cycle.
    assign w_s_ready = !reset && ((r_state == IDLE) ||
                                  ((r_state == SEND) && m_axis.tready && w_single));
    assign w_s_hs    = s_axis.tvalid && w_s_ready;
    assign w_m_hs    = (r_state == SEND) && m_axis.tready;
    assign w_s_null  = (s_axis.tkeep == '0);

    // State and beat registers.
    always_ff @(posedge ACLK) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_rem   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_data  <= w_data_n;
            r_rem   <= w_rem_n;
            r_last  <= w_last_n;
            r_err   <= w_err_n;
        end
    end

    // Next-state: drain the held beat; a same-cycle accept overrides the drain.
    always_comb begin
        w_state_n = r_state;
        w_data_n  = r_data;
        w_rem_n   = r_rem;
        w_last_n  = r_last;
        w_err_n   = 1'b0;

        if (w_m_hs) begin
            w_rem_n = r_rem & ~w_cur_oh;
            if (w_single) begin
                w_state_n = IDLE;
            end
        end

        if (w_s_hs) begin
            if (w_s_null) begin
                w_state_n = IDLE;
                w_err_n   = s_axis.tlast;
            end else begin
                w_state_n = SEND;
                w_data_n  = s_axis.tdata;
                w_rem_n   = s_axis.tkeep;
                w_last_n  = s_axis.tlast;
            end
        end
    end

    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = (r_state == SEND);
    assign m_axis.tdata  = r_data[BYTE_W * 32'(w_cur_idx) +: BYTE_W];
    assign m_axis.tlast  = r_last && w_single;
    assign m_axis.tkeep  = '1;
    assign err_null_last = r_err;

endmodule

// File: tb/tb_axis_byte_serializer.sv
// Scoreboarded bench for axis_byte_serializer: directed beats push their
// expected bytes, a negedge monitor pops and compares on each output handshake.
module tb_axis_byte_serializer;

    localparam int unsigned DW = 32;

    logic ACLK  = 1'b0;
    logic reset = 1'b1;
    logic err_null_last;

    always #5 ACLK = ~ACLK;

    axis_byte_serializer_if #(.DATA_W(DW)) s_if ();
    axis_byte_serializer_if #(.DATA_W(8))  m_if ();

    axis_byte_serializer #(.DATA_WIDTH(DW)) dut (
        .ACLK          (ACLK),
        .reset         (reset),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .err_null_last (err_null_last)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc   = 0;
    bit          stall_mode = 1'b0;
    logic [8:0]  exp_q[$];
    int unsigned pop_cyc[$];

    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;
    logic        prev_last  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic exp_byte(input logic [7:0] b, input logic l);
        exp_q.push_back({l, b});
    endtask

    always @(posedge ACLK) cyc <= cyc + 1;

    // Output backpressure: constant ready, or a random pattern while stalling.
    always @(posedge ACLK) begin
        #1;
        m_if.tready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Monitor: compare on handshakes, check stability while stalled.
    always @(negedge ACLK) begin
        logic [8:0] e;
        if (!reset) begin
            if (prev_stall && m_if.tvalid) begin
                check("stall_tdata", 32'(m_if.tdata), 32'(prev_data));
                check("stall_tlast", 32'(m_if.tlast), 32'(prev_last));
            end
            if (m_if.tvalid && !m_if.tready) begin
                check("stall_s_tready", 32'(s_if.tready), 32'd0);
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got 0x%0h last=%0b, required no byte", m_if.tdata, m_if.tlast);
                end else begin
                    e = exp_q.pop_front();
                    check("byte{last,data}", 32'({m_if.tlast, m_if.tdata}), 32'(e));
                    pop_cyc.push_back(cyc);
                end
            end
            prev_stall <= m_if.tvalid && !m_if.tready;
            prev_data  <= m_if.tdata;
            prev_last  <= m_if.tlast;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // Present one beat and hold it until accepted; returns at accept edge + 1.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        @(negedge ACLK);
        while (!s_if.tready && t < 200) begin
            @(negedge ACLK);
            t++;
        end
        if (!s_if.tready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: s_tready stayed 0, required 1");
        end
        @(posedge ACLK);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && t < 300) begin
            @(posedge ACLK);
            #1;
            t++;
        end
        if (exp_q.size() != 0 || m_if.tvalid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_drain: %0d bytes still pending, required 0", name, exp_q.size());
        end
    endtask

    // s_tready must be low for the first three bytes of a full beat, high on the fourth.
    task automatic check_ready_seq(input string name);
        check({name, "_s_tready_c1"}, 32'(s_if.tready), 32'd0);
        @(posedge ACLK); #1;
        check({name, "_s_tready_c2"}, 32'(s_if.tready), 32'd0);
        @(posedge ACLK); #1;
        check({name, "_s_tready_c3"}, 32'(s_if.tready), 32'd0);
        @(posedge ACLK); #1;
        check({name, "_s_tready_c4"}, 32'(s_if.tready), 32'd1);
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        reset       = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_m_tdata",  32'(m_if.tdata),  32'd0);
        check("rst_m_tlast",  32'(m_if.tlast),  32'd0);
        check("rst_err",      32'(err_null_last), 32'd0);
        check("rst_s_tready", 32'(s_if.tready), 32'd0);
        reset = 1'b0;
        #1;
        check("rel_s_tready", 32'(s_if.tready), 32'd1);

        // Full beat, single packet.
        exp_byte(8'h11, 1'b0); exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b0); exp_byte(8'h44, 1'b1);
        send_beat(32'h4433_2211, 4'b1111, 1'b1);
        check("t1_m_tvalid", 32'(m_if.tvalid), 32'd1);
        check_ready_seq("t1");
        wait_drain("t1");

        // Sparse keep: lanes 1 and 3 only.
        exp_byte(8'hBB, 1'b0); exp_byte(8'hDD, 1'b1);
        send_beat(32'hDDCC_BBAA, 4'b1010, 1'b1);
        wait_drain("t2");

        // Two full beats back-to-back: 8 bytes in 8 consecutive cycles.
        pop_cyc.delete();
        exp_byte(8'h11, 1'b0); exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b0); exp_byte(8'h44, 1'b0);
        exp_byte(8'h55, 1'b0); exp_byte(8'h66, 1'b0); exp_byte(8'h77, 1'b0); exp_byte(8'h88, 1'b1);
        send_beat(32'h4433_2211, 4'b1111, 1'b0);
        send_beat(32'h8877_6655, 4'b1111, 1'b1);
        check_ready_seq("t3");
        wait_drain("t3");
        check("t3_byte_count", pop_cyc.size(), 32'd8);
        if (pop_cyc.size() == 8) check("t3_span", pop_cyc[7] - pop_cyc[0], 32'd7);

        // Single-kept-byte beats back-to-back.
        pop_cyc.delete();
        exp_byte(8'h5A, 1'b0); exp_byte(8'hC3, 1'b1);
        send_beat(32'h0000_005A, 4'b0001, 1'b0);
        send_beat(32'h00C3_0000, 4'b0100, 1'b1);
        wait_drain("t4");
        check("t4_byte_count", pop_cyc.size(), 32'd2);
        if (pop_cyc.size() == 2) check("t4_span", pop_cyc[1] - pop_cyc[0], 32'd1);

        // Random output stalls: same byte sequence, outputs frozen while stalled.
        stall_mode = 1'b1;
        exp_byte(8'hA1, 1'b0); exp_byte(8'hA2, 1'b0); exp_byte(8'hA3, 1'b0); exp_byte(8'hA4, 1'b0);
        exp_byte(8'hB1, 1'b0); exp_byte(8'hB3, 1'b0); exp_byte(8'hB4, 1'b1);
        send_beat(32'hA4A3_A2A1, 4'b1111, 1'b0);
        send_beat(32'hB4B3_B2B1, 4'b1101, 1'b1);
        wait_drain("t5");
        stall_mode = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;

        // Null beats: with tlast pulses the error, without is silently dropped.
        send_beat(32'hDEAD_BEEF, 4'b0000, 1'b1);
        check("t6_err_pulse",  32'(err_null_last), 32'd1);
        check("t6_m_tvalid",   32'(m_if.tvalid),   32'd0);
        check("t6_s_tready",   32'(s_if.tready),   32'd1);
        @(posedge ACLK); #1;
        check("t6_err_cleared", 32'(err_null_last), 32'd0);
        send_beat(32'hCAFE_F00D, 4'b0000, 1'b0);
        check("t6_no_err",     32'(err_null_last), 32'd0);
        check("t6_m_tvalid2",  32'(m_if.tvalid),   32'd0);
        @(posedge ACLK); #1;
        check("t6_no_err2",    32'(err_null_last), 32'd0);

        // Reset after two of four bytes: remainder discarded.
        exp_byte(8'h01, 1'b0); exp_byte(8'h02, 1'b0); exp_byte(8'h03, 1'b0); exp_byte(8'h04, 1'b1);
        send_beat(32'h0403_0201, 4'b1111, 1'b1);
        @(posedge ACLK);
        @(posedge ACLK);
        #1;
        reset = 1'b1;
        check("t7_bytes_left", exp_q.size(), 32'd2);
        exp_q.delete();
        @(posedge ACLK); #1;
        check("t7_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("t7_m_tdata",  32'(m_if.tdata),  32'd0);
        check("t7_m_tlast",  32'(m_if.tlast),  32'd0);
        check("t7_s_tready", 32'(s_if.tready), 32'd0);
        reset = 1'b0;
        #1;
        check("t7_rel_s_tready", 32'(s_if.tready), 32'd1);
        exp_byte(8'h0D, 1'b0); exp_byte(8'h0C, 1'b0); exp_byte(8'h0B, 1'b0); exp_byte(8'h0A, 1'b1);
        send_beat(32'h0A0B_0C0D, 4'b1111, 1'b1);
        wait_drain("t7");

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
